// File: rtl/vp_key_arbiter.sv
// Merges PS/2 key events and gamepad numpad level changes into one FIFO, paced out to vp_keymap.
// Optional typematic repeat suppression on the PS/2 path: define VP_KEY_TYPEMATIC_FILTER_EN.
module vp_key_arbiter #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 716000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_stb_i,
    input  logic [7:0] ps2_ascii_i,
    input  logic       ps2_released_i,
    input  logic [9:0] joy_numpad_i,
    output logic       rx_data_ready_o,
    output logic [7:0] rx_ascii_o,
    output logic       rx_released_o,
    output logic       overflow_o,
    output logic       busy_o
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = 20;
    localparam int unsigned NK = 10;

    typedef struct packed {
        logic       released;
        logic [7:0] ascii;
    } key_event_t;

    typedef enum logic {IDLE, GAP} state_t;

    // Numpad bit k maps to "1".."9" for k=0..8 and "0" for k=9.
    function automatic logic [7:0] key_ascii(input int unsigned k);
        return (k < 9) ? 8'(32'h31 + k) : 8'h30;
    endfunction

    key_event_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          full_c, empty_c;

    logic          ps2_mapped_c, ps2_repeat_c, ps2_accept_c;
    logic [NK-1:0] joy_prev, joy_pending, joy_reported, joy_clear_c;
    logic [3:0]    joy_sel_c;
    logic          joy_hit_c, joy_service_c, joy_level_c, joy_wr_c;

    logic          wr_en_c, pop_c;
    key_event_t    wr_data_c;

    state_t        state, state_next;
    logic [GW-1:0] gap_cnt, gap_next;

    assign full_c  = (count == CW'(FIFO_DEPTH));
    assign empty_c = (count == '0);

    assign ps2_mapped_c = ps2_stb_i && (ps2_ascii_i != 8'h00);
    assign ps2_accept_c = ps2_mapped_c && !ps2_repeat_c && !full_c;

`ifdef VP_KEY_TYPEMATIC_FILTER_EN
    logic       last_valid;
    logic [7:0] last_ascii;

    assign ps2_repeat_c = !ps2_released_i && last_valid && (ps2_ascii_i == last_ascii);

    // Remember the last accepted press so auto-repeat strobes of the same key are dropped.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_valid <= 1'b0;
            last_ascii <= 8'h00;
        end else if (ps2_accept_c && !ps2_released_i) begin
            last_valid <= 1'b1;
            last_ascii <= ps2_ascii_i;
        end else if (ps2_mapped_c && ps2_released_i && (ps2_ascii_i == last_ascii)) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign ps2_repeat_c = 1'b0;
`endif

    // Lowest pending numpad bit wins the service slot.
    always_comb begin
        joy_hit_c = 1'b0;
        joy_sel_c = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (joy_pending[i]) begin
                joy_hit_c = 1'b1;
                joy_sel_c = 4'(i);
            end
        end
    end

    assign joy_service_c = joy_hit_c && !ps2_accept_c && !full_c;
    assign joy_level_c   = joy_numpad_i[joy_sel_c];
    assign joy_wr_c      = joy_service_c && (joy_level_c != joy_reported[joy_sel_c]);
    assign joy_clear_c   = joy_service_c ? (NK'(1) << joy_sel_c) : '0;

    assign wr_en_c = ps2_accept_c || joy_wr_c;

    always_comb begin
        wr_data_c = '0;
        if (ps2_accept_c) begin
            wr_data_c.released = ps2_released_i;
            wr_data_c.ascii    = ps2_ascii_i;
        end else begin
            wr_data_c.released = ~joy_level_c;
            wr_data_c.ascii    = key_ascii(32'(joy_sel_c));
        end
    end

    // Output pacing: one pop per visit to IDLE, then GAP_CYCLES cycles in GAP.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop_c      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c      = 1'b1;
                    gap_next   = GW'(GAP_CYCLES - 1);
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign count_next = count + CW'(wr_en_c) - CW'(pop_c);

    always_ff @(posedge clk_sys) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= wr_data_c;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            joy_prev        <= '0;
            joy_pending     <= '0;
            joy_reported    <= '0;
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= 8'h00;
            rx_released_o   <= 1'b0;
            overflow_o      <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            state           <= state_next;
            gap_cnt         <= gap_next;
            count           <= count_next;
            joy_prev        <= joy_numpad_i;
            joy_pending     <= (joy_pending & ~joy_clear_c) | (joy_prev ^ joy_numpad_i);
            rx_data_ready_o <= pop_c;
            busy_o          <= (count_next != '0) || (state_next != IDLE);
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr        <= rd_ptr + AW'(1);
                rx_ascii_o    <= mem[rd_ptr].ascii;
                rx_released_o <= mem[rd_ptr].released;
            end
            if (joy_wr_c) begin
                joy_reported[joy_sel_c] <= joy_level_c;
            end
            if (ps2_mapped_c && !ps2_repeat_c && full_c) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vp_key_arbiter.sv
// Directed bench for vp_key_arbiter: a GAP_CYCLES=4 instance for timing/order/glitch/reset/filter
// and a GAP_CYCLES=1000 instance for FIFO overflow with a held numpad key behind it.
module tb_vp_key_arbiter;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    logic       reset_a, stb_a, rel_a, rdy_a, rxr_a, ovf_a, busy_a;
    logic [7:0] ascii_a, rxa_a;
    logic [9:0] joy_a;
    logic       reset_b, stb_b, rel_b, rdy_b, rxr_b, ovf_b, busy_b;
    logic [7:0] ascii_b, rxa_b;
    logic [9:0] joy_b;

    vp_key_arbiter #(.FIFO_DEPTH(8), .GAP_CYCLES(4)) dut_a (
        .clk_sys(clk_sys), .reset(reset_a), .ps2_stb_i(stb_a), .ps2_ascii_i(ascii_a),
        .ps2_released_i(rel_a), .joy_numpad_i(joy_a), .rx_data_ready_o(rdy_a),
        .rx_ascii_o(rxa_a), .rx_released_o(rxr_a), .overflow_o(ovf_a), .busy_o(busy_a)
    );

    vp_key_arbiter #(.FIFO_DEPTH(8), .GAP_CYCLES(1000)) dut_b (
        .clk_sys(clk_sys), .reset(reset_b), .ps2_stb_i(stb_b), .ps2_ascii_i(ascii_b),
        .ps2_released_i(rel_b), .joy_numpad_i(joy_b), .rx_data_ready_o(rdy_b),
        .rx_ascii_o(rxa_b), .rx_released_o(rxr_b), .overflow_o(ovf_b), .busy_o(busy_b)
    );

    logic [8:0] ev_a[$];
    int         evc_a[$];
    logic [8:0] ev_b[$];
    int         evc_b[$];

    always @(negedge clk_sys) begin
        if (rdy_a) begin
            ev_a.push_back({rxr_a, rxa_a});
            evc_a.push_back(cyc);
        end
        if (rdy_b) begin
            ev_b.push_back({rxr_b, rxa_b});
            evc_b.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ea(input int i);
        return (i < ev_a.size()) ? 32'(ev_a[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] ca(input int i);
        return (i < evc_a.size()) ? 32'(evc_a[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] eb(input int i);
        return (i < ev_b.size()) ? 32'(ev_b[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] cb(input int i);
        return (i < evc_b.size()) ? 32'(evc_b[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_a();
        ev_a.delete();
        evc_a.delete();
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        repeat (4) @(negedge clk_sys);
        while (busy_a && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check("idle_a_timeout", 32'(busy_a), 32'd0);
    endtask

    task automatic wait_idle_b(input int budget);
        int n = 0;
        repeat (4) @(negedge clk_sys);
        while (busy_b && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check("idle_b_timeout", 32'(busy_b), 32'd0);
    endtask

    initial begin
        int t0;
        reset_a = 1'b1; stb_a = 1'b0; ascii_a = 8'h00; rel_a = 1'b0; joy_a = '0;
        reset_b = 1'b1; stb_b = 1'b0; ascii_b = 8'h00; rel_b = 1'b0; joy_b = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_outs_a", 32'({rdy_a, rxa_a, rxr_a, ovf_a, busy_a}), 32'd0);
        check("rst_outs_b", 32'({rdy_b, rxa_b, rxr_b, ovf_b, busy_b}), 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("idle_busy_a", 32'(busy_a), 32'd0);

        // Single PS/2 press: pulse two cycles after the strobe, busy through the gap.
        clear_a();
        t0 = cyc; stb_a = 1'b1; ascii_a = 8'h61; rel_a = 1'b0;
        @(negedge clk_sys); stb_a = 1'b0; ascii_a = 8'h00;
        check("t1_busy_rise", 32'(busy_a), 32'd1);
        repeat (4) @(negedge clk_sys);
        check("t1_busy_gap_end", 32'(busy_a), 32'd1);
        @(negedge clk_sys);
        check("t1_busy_fall", 32'(busy_a), 32'd0);
        check("t1_count", 32'(ev_a.size()), 32'd1);
        check("t1_data", ea(0), 32'h061);
        check("t1_latency", ca(0) - 32'(t0), 32'd2);

        // Unmapped code is discarded.
        clear_a();
        stb_a = 1'b1; ascii_a = 8'h00;
        @(negedge clk_sys); stb_a = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("t1_unmapped_busy", 32'(busy_a), 32'd0);
        check("t1_unmapped_count", 32'(ev_a.size()), 32'd0);

        // Numpad burst "1" and "3" pressed, then released.
        clear_a();
        t0 = cyc; joy_a = 10'h005;
        wait_idle_a(100);
        check("t2_press_count", 32'(ev_a.size()), 32'd2);
        check("t2_press0", ea(0), 32'h031);
        check("t2_press1", ea(1), 32'h033);
        check("t2_press0_cyc", ca(0) - 32'(t0), 32'd3);
        check("t2_press1_cyc", ca(1) - 32'(t0), 32'd8);
        clear_a();
        joy_a = 10'h000;
        wait_idle_a(100);
        check("t2_rel_count", 32'(ev_a.size()), 32'd2);
        check("t2_rel0", ea(0), 32'h131);
        check("t2_rel1", ea(1), 32'h133);
        check("t2_spacing", ca(1) - ca(0), 32'd5);

        // Fill FIFO, glitch numpad bit 4 for one cycle while full: no "5" event.
        clear_a();
        for (int i = 0; i < 10; i++) begin
            stb_a = 1'b1; ascii_a = 8'(8'h41 + i); rel_a = 1'b0;
            @(negedge clk_sys);
        end
        stb_a = 1'b0; ascii_a = 8'h00;
        joy_a = 10'h010;
        @(negedge clk_sys); joy_a = 10'h000;
        wait_idle_a(200);
        check("t3_count", 32'(ev_a.size()), 32'd10);
        check("t3_ovf", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_order%0d", i), ea(i), 32'(8'h41 + i));
        end
        clear_a();
        t0 = cyc; joy_a = 10'h010;
        wait_idle_a(100);
        check("t3_after_press", ea(0), 32'h035);
        check("t3_after_cyc", ca(0) - 32'(t0), 32'd3);
        clear_a();
        joy_a = 10'h000;
        wait_idle_a(100);
        check("t3_after_rel", ea(0), 32'h135);

        // PS/2 and numpad in the same cycle: PS/2 first.
        clear_a();
        t0 = cyc; stb_a = 1'b1; ascii_a = 8'h5A; rel_a = 1'b0; joy_a = 10'h001;
        @(negedge clk_sys); stb_a = 1'b0; ascii_a = 8'h00;
        wait_idle_a(100);
        check("t4_count", 32'(ev_a.size()), 32'd2);
        check("t4_first", ea(0), 32'h05A);
        check("t4_second", ea(1), 32'h031);
        check("t4_first_cyc", ca(0) - 32'(t0), 32'd2);
        check("t4_second_cyc", ca(1) - 32'(t0), 32'd7);
        clear_a();
        joy_a = 10'h000;
        wait_idle_a(100);
        check("t4_rel", ea(0), 32'h131);

        // Reset during GAP; held "7" re-emits after reset release.
        clear_a();
        joy_a = 10'h040;
        repeat (4) @(negedge clk_sys);
        check("t5_pre_busy", 32'(busy_a), 32'd1);
        reset_a = 1'b1;
        @(negedge clk_sys);
        check("t5_rst_outs", 32'({rdy_a, rxa_a, rxr_a, ovf_a, busy_a}), 32'd0);
        @(negedge clk_sys);
        reset_a = 1'b0;
        clear_a();
        t0 = cyc;
        wait_idle_a(100);
        check("t5_count", 32'(ev_a.size()), 32'd1);
        check("t5_repress", ea(0), 32'h037);
        check("t5_repress_cyc", ca(0) - 32'(t0), 32'd3);
        clear_a();
        joy_a = 10'h000;
        wait_idle_a(100);
        check("t5_rel", ea(0), 32'h137);

        // Three presses of 0x62 then a release.
        clear_a();
        for (int i = 0; i < 4; i++) begin
            stb_a = 1'b1; ascii_a = 8'h62; rel_a = (i == 3);
            @(negedge clk_sys);
            stb_a = 1'b0;
            @(negedge clk_sys);
        end
        ascii_a = 8'h00; rel_a = 1'b0;
        wait_idle_a(200);
`ifdef VP_KEY_TYPEMATIC_FILTER_EN
        check("t6_count", 32'(ev_a.size()), 32'd2);
        check("t6_first", ea(0), 32'h062);
        check("t6_last", ea(1), 32'h162);
`else
        check("t6_count", 32'(ev_a.size()), 32'd4);
        check("t6_first", ea(0), 32'h062);
        check("t6_last", ea(3), 32'h162);
`endif

        // Overflow on the slow instance; held "2" enters once a slot frees.
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check("t7_ovf_before", 32'(ovf_b), 32'd0);
            stb_b = 1'b1; ascii_b = 8'(8'h61 + i); rel_b = 1'b0;
            @(negedge clk_sys);
        end
        stb_b = 1'b0; ascii_b = 8'h00;
        joy_b = 10'h002;
        check("t7_ovf_set", 32'(ovf_b), 32'd1);
        wait_idle_b(12000);
        check("t7_count", 32'(ev_b.size()), 32'd10);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t7_order%0d", i), eb(i), 32'(8'h61 + i));
        end
        check("t7_joy_last", eb(9), 32'h032);
        check("t7_spacing", cb(1) - cb(0), 32'd1001);
        check("t7_ovf_sticky", 32'(ovf_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
